pipe_seq_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline's keep_*/flush_* controls. Combines data-bus wait states,
//  EX-stage redirects, load-use stalls and a debug halt/drain handshake into one set of
//  per-stage hold/bubble commands. Sits beside the forwarding/hazard detector; owns all stall policy.

---
 rtl/pipe_seq_ctrl_pkg.sv | 31 +++
 rtl/pipe_seq_ctrl_sat_counter.sv | 30 +++
 rtl/pipe_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller:
// FSM state encoding and keep/flush resolution helper.
package pipe_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERR    = 2'd3
    } seq_state_e;

    // Bit order for both vectors, MSB first:
    // keep : PC, IF_ID, ID_EX, EX_MEM, MEM_WB
    // flush:     IF_ID, ID_EX, EX_MEM, MEM_WB
    localparam logic [4:0] K_ALL_BUT_WB = 5'b11110;
    localparam logic [4:0] K_FETCH      = 5'b10000;
    localparam logic [4:0] K_FETCH_DEC  = 5'b11000;
    localparam logic [3:0] F_WB         = 4'b0001;
    localparam logic [3:0] F_IF         = 4'b1000;
    localparam logic [3:0] F_IF_EX      = 4'b1100;
    localparam logic [3:0] F_EX         = 4'b0100;

    // A held stage register never also loads a bubble.
    function automatic logic [3:0] keep_wins(
        input logic [3:0] flush,
        input logic [4:0] keep
    );
        return flush & ~keep[3:0];
    endfunction

endpackage

// File: rtl/pipe_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk_i, clr_i (sync clear), inc_i, cnt_o (count, stops at all-ones).
module pipe_seq_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline stall/flush sequencer: bus waits, redirects, load-use, debug halt drain.
// Ports: hazard/bus/halt inputs (_i); per-stage keep_*/flush_*, halt_ack, bus_err, stall_cnt (_o).
module pipe_seq_ctrl
    import pipe_seq_ctrl_pkg::*;
#(
    parameter int TMO_CYC   = 255,
    parameter int TMO_W     = 8,
    parameter int DRAIN_CYC = 4,
    parameter int PERF_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_use_hz_i,
    input  logic              npc_op_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    input  logic              halt_req_i,
    output logic              keep_PC_o,
    output logic              keep_IF_ID_o,
    output logic              keep_ID_EX_o,
    output logic              keep_EX_MEM_o,
    output logic              keep_MEM_WB_o,
    output logic              flush_IF_ID_o,
    output logic              flush_ID_EX_o,
    output logic              flush_EX_MEM_o,
    output logic              flush_MEM_WB_o,
    output logic              halt_ack_o,
    output logic              bus_err_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    localparam int DW = $clog2(DRAIN_CYC) + 1;

    seq_state_e        state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DW-1:0]     drn_q, drn_d;
    logic              mem_stall;
    logic [4:0]        keep;
    logic [3:0]        flush;
    logic [3:0]        flush_eff;
    logic              ack, err;
    logic [PERF_W-1:0] cnt;

    assign mem_stall = dmem_req_i & ~dmem_ack_i;

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        drn_d   = drn_q;
        unique case (state_q)
            ST_RUN, ST_DRAIN: begin
                if (mem_stall) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                        state_d = ST_ERR;
                    end else if (state_q == ST_DRAIN && !halt_req_i) begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_RUN) begin
                    if (halt_req_i) begin
                        state_d = ST_DRAIN;
                        drn_d   = '0;
                    end
                end else if (!halt_req_i) begin
                    state_d = ST_RUN;
                end else if (npc_op_i || load_use_hz_i) begin
                    // new work entered the pipe: drain window restarts
                    drn_d = '0;
                end else if (drn_q == DW'(DRAIN_CYC - 1)) begin
                    state_d = ST_HALTED;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            ST_HALTED: begin
                if (!halt_req_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_ERR: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            tmo_q   <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        keep  = '0;
        flush = '0;
        ack   = 1'b0;
        err   = 1'b0;
        if (rst_i) begin
            flush = 4'b1111;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        keep  = K_ALL_BUT_WB;
                        flush = F_WB;
                    end else if (npc_op_i) begin
                        flush = F_IF_EX;
                    end else if (load_use_hz_i) begin
                        keep  = K_FETCH_DEC;
                        flush = F_EX;
                    end
                end
                ST_DRAIN: begin
                    if (mem_stall) begin
                        keep  = K_ALL_BUT_WB;
                        flush = F_WB;
                    end else if (npc_op_i) begin
                        // PC takes the target and becomes the resume point
                        flush = F_IF_EX;
                    end else if (load_use_hz_i) begin
                        keep  = K_FETCH_DEC;
                        flush = F_IF_EX;
                    end else begin
                        keep  = K_FETCH;
                        flush = F_IF;
                    end
                end
                ST_HALTED: begin
                    keep  = K_FETCH;
                    flush = F_IF;
                    ack   = 1'b1;
                end
                ST_ERR: begin
                    keep  = K_ALL_BUT_WB;
                    flush = F_WB;
                    err   = 1'b1;
                end
            endcase
        end
    end

    assign flush_eff = keep_wins(flush, keep);

    assign keep_PC_o      = keep[4];
    assign keep_IF_ID_o   = keep[3];
    assign keep_ID_EX_o   = keep[2];
    assign keep_EX_MEM_o  = keep[1];
    assign keep_MEM_WB_o  = keep[0];
    assign flush_IF_ID_o  = flush_eff[3];
    assign flush_ID_EX_o  = flush_eff[2];
    assign flush_EX_MEM_o = flush_eff[1];
    assign flush_MEM_WB_o = flush_eff[0];
    assign halt_ack_o     = ack;
    assign bus_err_o      = err;

    pipe_seq_ctrl_sat_counter #(
        .W(PERF_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (keep[4]),
        .cnt_o (cnt)
    );

    // count register is cleared on the reset edge; mask it while reset is held
    assign stall_cnt_o = rst_i ? '0 : cnt;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl with a behavioural reference model
// compared every cycle plus literal spot checks.
module tb_pipe_seq_ctrl;

    localparam int TMO  = 8;
    localparam int DRN  = 4;
    localparam int PW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lu = 1'b0, npc = 1'b0, req = 1'b0, ack = 1'b0, halt = 1'b0;
    logic k_pc, k_ifid, k_idex, k_exmem, k_memwb;
    logic f_ifid, f_idex, f_exmem, f_memwb;
    logic hack, berr;
    logic [PW-1:0] scnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_seq_ctrl #(
        .TMO_CYC(TMO), .TMO_W(8), .DRAIN_CYC(DRN), .PERF_W(PW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .load_use_hz_i(lu), .npc_op_i(npc),
        .dmem_req_i(req), .dmem_ack_i(ack), .halt_req_i(halt),
        .keep_PC_o(k_pc), .keep_IF_ID_o(k_ifid), .keep_ID_EX_o(k_idex),
        .keep_EX_MEM_o(k_exmem), .keep_MEM_WB_o(k_memwb),
        .flush_IF_ID_o(f_ifid), .flush_ID_EX_o(f_idex),
        .flush_EX_MEM_o(f_exmem), .flush_MEM_WB_o(f_memwb),
        .halt_ack_o(hack), .bus_err_o(berr), .stall_cnt_o(scnt)
    );

    // Reference model: pipeline mode as flags, drain as cycles remaining.
    bit      m_err = 0, m_draining = 0, m_halted = 0;
    int      m_left = 0;
    int      m_wait = 0;
    int      m_cnt = 0;

    function automatic logic [10:0] model_out();
        logic [4:0] k;
        logic [3:0] f;
        logic a, e, st;
        k = '0; f = '0; a = 0; e = 0;
        st = req & ~ack;
        if (rst) f = 4'b1111;
        else if (m_err) begin k = 5'b11110; f = 4'b0001; e = 1; end
        else if (m_halted) begin k = 5'b10000; f = 4'b1000; a = 1; end
        else if (st) begin k = 5'b11110; f = 4'b0001; end
        else if (m_draining) begin
            k = 5'b10000; f = 4'b1000;
            if (npc) begin k[4] = 0; f[2] = 1; end
            else if (lu) begin k[3] = 1; f[2] = 1; end
        end
        else if (npc) f = 4'b1100;
        else if (lu) begin k = 5'b11000; f = 4'b0100; end
        f = f & ~k[3:0];
        return {k, f, a, e};
    endfunction

    always @(posedge clk) begin
        logic [10:0] o;
        o = model_out();
        if (rst) begin
            m_err <= 0; m_draining <= 0; m_halted <= 0;
            m_wait <= 0; m_left <= 0; m_cnt <= 0;
        end else begin
            if (o[10] && m_cnt < (1 << PW) - 1) m_cnt <= m_cnt + 1;
            if (m_err) begin
            end else if (m_halted) begin
                if (!halt) m_halted <= 0;
            end else if (req && !ack) begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 == TMO) begin
                    m_err <= 1; m_draining <= 0;
                end else if (m_draining && !halt) m_draining <= 0;
            end else begin
                m_wait <= 0;
                if (!m_draining) begin
                    if (halt) begin m_draining <= 1; m_left <= DRN; end
                end else if (!halt) m_draining <= 0;
                else if (npc || lu) m_left <= DRN;
                else if (m_left == 1) begin
                    m_draining <= 0; m_halted <= 1;
                end else m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [10:0] exp_v, got_v;
        logic [PW-1:0] exp_c;
        exp_v = model_out();
        got_v = {k_pc, k_ifid, k_idex, k_exmem, k_memwb,
                 f_ifid, f_idex, f_exmem, f_memwb, hack, berr};
        exp_c = rst ? '0 : PW'(m_cnt);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL ctrl_vec t=%0t got=%b exp=%b", $time, got_v, exp_v);
        end
        n_chk++;
        if (scnt !== exp_c) begin
            n_fail++;
            $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, scnt, exp_c);
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] ex);
        n_chk++;
        if (got !== ex) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, ex);
        end
    endtask

    // apply one cycle of inputs, return at the following falling edge
    task automatic drive(input logic rq, ak, np, l, h);
        @(posedge clk);
        #1;
        req = rq; ack = ak; npc = np; lu = l; halt = h;
        @(negedge clk);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        lit("rst_keep_pc", 32'(k_pc), 0);
        lit("rst_flush_all", 32'({f_ifid, f_idex, f_exmem, f_memwb}), 32'hF);
        lit("rst_stall_cnt", 32'(scnt), 0);
        rst = 0;
        drive(0, 0, 0, 0, 0);

        // three wait cycles then ack
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            lit("wait_keep", 32'({k_pc, k_ifid, k_idex, k_exmem}), 32'hF);
            lit("wait_flush_wb", 32'(f_memwb), 1);
        end
        drive(1, 1, 0, 0, 0);
        lit("ack_release", 32'(k_pc), 0);
        lit("ack_stall_cnt", 32'(scnt), 3);
        drive(0, 0, 0, 0, 0);

        // redirect beats load-use, then load-use alone
        drive(0, 0, 1, 1, 0);
        lit("redir_flush", 32'({f_ifid, f_idex}), 3);
        lit("redir_keep_pc", 32'(k_pc), 0);
        drive(0, 0, 0, 1, 0);
        lit("lu_vec", 32'({k_pc, k_ifid, f_idex}), 7);

        // clean drain to halt
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            lit("drain_no_ack", 32'(hack), 0);
        end
        drive(0, 0, 0, 0, 1);
        lit("halt_ack", 32'(hack), 1);
        drive(0, 0, 0, 0, 0);
        lit("halt_ack_hold", 32'(hack), 1);
        drive(0, 0, 0, 0, 0);
        lit("resume_ack0", 32'(hack), 0);

        // aborted drain, with load-use and a bus wait inside the drain
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1);
        lit("drain_lu", 32'({k_ifid, f_ifid, f_idex}), 32'b101);
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        lit("abort_run", 32'(k_pc), 0);

        // redirect in second drain cycle restarts the drain
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        lit("drain_npc_pc", 32'(k_pc), 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            lit("redrain_no_ack", 32'(hack), 0);
        end
        drive(0, 0, 0, 0, 1);
        lit("redrain_ack", 32'(hack), 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // bus timeout
        for (int i = 0; i < TMO; i++) drive(1, 0, 0, 0, 0);
        lit("pre_tmo_err", 32'(berr), 0);
        drive(1, 0, 0, 0, 0);
        lit("tmo_err", 32'(berr), 1);
        drive(0, 0, 1, 1, 1);
        lit("err_sticky", 32'({berr, k_pc, hack}), 32'b110);
        lit("stall_sat", 32'(scnt), 32'hF);
        rst = 1;
        drive(0, 0, 0, 0, 0);
        lit("err_rst", 32'(berr), 0);
        rst = 0;
        drive(0, 0, 0, 0, 0);

        // reset in the middle of a drain and of a bus wait
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        rst = 1;
        drive(0, 0, 0, 0, 1);
        lit("rst_drain", 32'({k_pc, f_ifid, f_memwb, hack}), 32'b0110);
        rst = 0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst = 1;
        drive(1, 0, 0, 0, 0);
        lit("rst_wait_keep", 32'({k_pc, k_exmem, scnt}), 0);
        rst = 0;
        drive(0, 0, 0, 0, 0);
        lit("post_rst_run", 32'({k_pc, f_ifid, f_memwb, berr}), 0);
        drive(0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
